// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin packet arbiter.
//
// Contents:
//   arb_state_t - arbiter FSM state (idle / grant held for a packet)
//   RR_MAX_N    - widest request vector rr_pick accepts
//   rr_pick     - rotating-priority search over a request vector
package arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_t;

  // rr_pick takes a fixed-width request vector so that one function serves
  // every instance size; narrower vectors are zero-extended by the caller.
  localparam int unsigned RR_MAX_N  = 64;
  localparam int unsigned RR_IDX_W  = $clog2(RR_MAX_N);

  // Returns the first index i in the order ptr, ptr+1, ..., ptr+n-1 (mod n)
  // with valid[i] set. If nothing is valid, ptr is returned unchanged; the
  // caller only uses the result when at least one request is present.
  // The loop runs from the far end back toward ptr so the last assignment
  // made is the nearest requester, which keeps the logic a flat priority
  // chain after unrolling.
  function automatic int rr_pick(
    input logic [RR_MAX_N-1:0] valid,
    input int                  ptr,
    input int                  n
  );
    int                  pick;
    logic [RR_IDX_W-1:0] idx;
    pick = ptr;
    for (int k = RR_MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = RR_IDX_W'((ptr + k) % n);
        if (valid[idx]) begin
          pick = int'(idx);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Generic N:1 data multiplexer (the mux8 of the original design, widened to
// any power-of-two N and any data width W).
//
// Ports:
//   data  - N*W packed inputs; input i occupies data[i*W +: W]
//   sel   - index of the input to forward
//   y     - selected input, purely combinational
module mux_n #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]   y
);

  logic [W-1:0] lane [N];

  // Unpack the flat bus so the select is a plain array index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = data[gi*W +: W];
    end
  endgenerate

  // N is a power of two, so every sel value addresses a real lane.
  assign y = lane[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin, packet-locked arbiter sharing one output stream among N
// requesters. A requester is granted on the cycle after it is seen in the
// idle state and keeps the grant until its `last` beat transfers; priority
// then rotates to the requester after it.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   in_valid    - per-requester beat valid
//   in_data     - packed requester data, requester i at [i*W +: W]
//   in_last     - per-requester final beat marker
//   in_ready    - per-requester accept, at most one bit high
//   out_valid   - beat valid toward the consumer
//   out_data    - muxed data (always driven from the selected requester)
//   out_last    - muxed last
//   out_ready   - consumer accept
//   sel         - current grant index / mux select
//   busy        - high while a packet grant is held
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  arb_state_t       state_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] pick_next;
  logic             grant_active;
  logic             beat_done;

  // Rotating-priority search starting at ptr_reg.
  always_comb begin
    pick_next = SEL_W'(rr_pick(RR_MAX_N'(in_valid), int'(ptr_reg), int'(N)));
  end

  // Outputs are held quiet while reset is asserted, so a reset mid-packet
  // never lets another beat through even before the state register clears.
  assign grant_active = (state_reg == S_GRANT) && !rst;
  assign beat_done    = out_valid && out_ready;

  assign busy      = grant_active;
  assign sel       = sel_reg;
  assign out_valid = grant_active && in_valid[sel_reg];
  assign out_last  = grant_active && in_last[sel_reg];

  // Only the granted requester sees the consumer's ready.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = grant_active && (sel_reg == SEL_W'(gi)) && out_ready;
    end
  endgenerate

  // Data path goes through the mux in every state; out_valid qualifies it.
  mux_n #(
    .N     (N),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .data (in_data),
    .sel  (sel_reg),
    .y    (out_data)
  );

  // Grant FSM. Requests from other inputs are not looked at while a grant is
  // held, which is what locks the output to one packet at a time. The pointer
  // wraps naturally because N is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|in_valid) begin
            sel_reg   <= pick_next;
            state_reg <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (beat_done && out_last) begin
            ptr_reg   <= sel_reg + SEL_W'(1);
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data = '0;
  logic [N-1:0]     in_last = '0;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic [SEL_W-1:0] sel;
  logic             busy;

  rr_mux_arbiter #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Reference state: whether a packet grant is held, who holds it, and who
  // has first priority at the next arbitration.
  bit m_busy = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int grants[$];

  // Last observed outputs, for directed checks against fixed constants.
  logic [SEL_W-1:0] obs_sel;
  logic [W-1:0]     obs_data;
  logic [N-1:0]     obs_ready;
  logic             obs_valid;
  logic             obs_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, then advance the model to match the coming rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic [N-1:0] l, input logic rdy, input logic r);
    logic          e_busy, e_valid, e_last;
    logic [N-1:0]  e_ready;
    logic [W-1:0]  e_data;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = rdy;
    rst       = r;
    #1;
    e_busy  = m_busy && !r;
    e_data  = d[m_sel*W +: W];
    e_valid = e_busy && v[m_sel];
    e_last  = e_busy && l[m_sel];
    e_ready = e_busy && rdy ? N'(1) << m_sel : '0;
    check("busy",      64'(busy),      64'(e_busy));
    check("sel",       64'(sel),       64'(m_sel));
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_last",  64'(out_last),  64'(e_last));
    check("in_ready",  64'(in_ready),  64'(e_ready));
    check("out_data",  64'(out_data),  64'(e_data));
    obs_sel   = sel;
    obs_data  = out_data;
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_busy  = busy;
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (v != '0) begin
        m_sel  = model_pick(v, m_ptr);
        m_busy = 1;
        grants.push_back(m_sel);
      end
    end else if (v[m_sel] && rdy && l[m_sel]) begin
      m_ptr  = (m_sel + 1) % N;
      m_busy = 0;
    end
    cycle++;
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    logic           rdy;
    int             g0, beats;

    // 1. Reset then idle.
    step('0, rnd_data(), '0, 1'b1, 1'b1);
    step('0, rnd_data(), '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step('0, rnd_data(), '0, 1'b1, 1'b0);
    check("t1_busy", 64'(obs_busy), 64'd0);
    check("t1_ready", 64'(obs_ready), 64'd0);

    // 2. Single requester 3 with a one-beat packet.
    d = rnd_data();
    d[3*W +: W] = 8'hA5;
    step(8'h08, d, 8'h08, 1'b1, 1'b0);
    step(8'h08, d, 8'h08, 1'b1, 1'b0);
    check("t2_sel", 64'(obs_sel), 64'd3);
    check("t2_data", 64'(obs_data), 64'hA5);
    check("t2_ready", 64'(obs_ready), 64'h08);
    step('0, rnd_data(), '0, 1'b1, 1'b0);
    check("t2_idle", 64'(obs_busy), 64'd0);
    // Pointer should now be 4: with everyone requesting, 4 wins.
    step(8'hFF, rnd_data(), 8'hFF, 1'b1, 1'b0);
    step(8'hFF, rnd_data(), 8'hFF, 1'b1, 1'b0);
    check("t2_ptr", 64'(obs_sel), 64'd4);
    step('0, rnd_data(), '0, 1'b0, 1'b1);

    // 3. Round-robin with all requesting single-beat packets.
    g0 = grants.size();
    for (int i = 0; i < 18; i++) step(8'hFF, rnd_data(), 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) check("t3_order", 64'(grants[g0 + i]), 64'(i % N));
    step('0, rnd_data(), '0, 1'b1, 1'b0);

    // 4. Packet lock with backpressure: req 2 (3 beats) versus req 5.
    step(8'h24, rnd_data(), 8'h20, 1'b1, 1'b0);
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      rdy = (i % 2 == 0);
      l = 8'h20;
      if (beats == 2) l[2] = 1'b1;
      step(8'h24, rnd_data(), l, rdy, 1'b0);
      check("t4_sel", 64'(obs_sel), 64'd2);
      if (rdy) beats++;
    end
    step(8'h20, rnd_data(), 8'h20, 1'b1, 1'b0);
    check("t4_bubble", 64'(obs_valid), 64'd0);
    step(8'h20, rnd_data(), 8'h20, 1'b1, 1'b0);
    check("t4_next", 64'(obs_sel), 64'd5);
    check("t4_grants", 64'(grants[grants.size() - 1]), 64'd5);
    step('0, rnd_data(), '0, 1'b1, 1'b0);

    // 5. Granted req 6 pauses for two cycles mid-packet.
    step(8'h40, rnd_data(), '0, 1'b1, 1'b0);
    step(8'h40, rnd_data(), '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(8'h02, rnd_data(), '0, 1'b1, 1'b0);
      check("t5_gap_valid", 64'(obs_valid), 64'd0);
      check("t5_gap_sel", 64'(obs_sel), 64'd6);
    end
    step(8'h40, rnd_data(), '0, 1'b1, 1'b0);
    step(8'h40, rnd_data(), 8'h40, 1'b1, 1'b0);
    step('0, rnd_data(), '0, 1'b1, 1'b0);

    // 6. Reset during beat 2 of req 1's packet.
    step(8'h02, rnd_data(), '0, 1'b1, 1'b0);
    step(8'h02, rnd_data(), '0, 1'b1, 1'b0);
    step(8'h02, rnd_data(), '0, 1'b1, 1'b1);
    step(8'h02, rnd_data(), '0, 1'b1, 1'b0);
    check("t6_busy", 64'(obs_busy), 64'd0);
    check("t6_ready", 64'(obs_ready), 64'd0);
    step(8'h02, rnd_data(), 8'h02, 1'b1, 1'b0);
    check("t6_regrant", 64'(obs_sel), 64'd1);
    check("t6_ready1", 64'(obs_ready), 64'h02);
    step('0, rnd_data(), '0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] v;
      v   = ($urandom_range(0, 9) == 0) ? '1 : N'($urandom & $urandom);
      l   = N'($urandom & $urandom);
      rdy = ($urandom_range(0, 9) < 7);
      step(v, rnd_data(), l, rdy, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one output stream between N requesters.
- Drives the select of an N:1 mux (mux8 when N=8) and gates each requester's ready.
- Grant is held from the first beat to the `last` beat of a packet, then rotates.
- Sits in front of any shared downstream consumer (UART TX, display driver, memory port).

Parameters:
- N, 8, number of requesters; power of two, ≥2.
- W, 8, data width per requester.
- SEL_W, $clog2(N), width of select/index.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-requester beat valid.
- in_data  input  N*W  packed requester data; requester i at [i*W +: W].
- in_last  input  N  per-requester final beat of packet.
- in_ready  output  N  per-requester accept; at most one bit high.
- out_valid  output  1  beat valid toward consumer.
- out_data  output  W  muxed data.
- out_last  output  1  muxed last.
- out_ready  input  1  consumer accept.
- sel  output  SEL_W  current grant index; drives mux select.
- busy  output  1  high while in GRANT state.

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, sel=0, ptr=0, busy=0. Outputs during reset: in_ready=0, out_valid=0, out_last=0.
- Registers: state {IDLE, GRANT}, sel[SEL_W], ptr[SEL_W] (next-priority index).
- IDLE:
  - in_ready=0, out_valid=0, out_last=0, busy=0.
  - If any in_valid: sel <= lowest index i scanning ptr, ptr+1, …, ptr+N-1 (mod N) with in_valid[i]=1; state <= GRANT.
  - Arbitration latency is 1 cycle: a request seen in cycle t is first presented downstream in cycle t+1.
- GRANT:
  - busy=1.
  - out_valid=in_valid[sel], out_data=in_data[sel], out_last=in_last[sel]; combinational through the mux.
  - in_ready[sel]=out_ready; all other in_ready bits 0.
  - A beat transfers when out_valid && out_ready.
  - Transfer with out_last=1: ptr <= (sel+1) mod N, state <= IDLE.
  - All other cycles: sel and ptr hold.
- Bubble: one idle cycle between packets; back-to-back packets from different requesters are separated by exactly 1 cycle with out_valid=0.
- Locking:
  - A granted requester dropping in_valid mid-packet keeps the grant; out_valid=0 until it resumes.
  - Other requesters' valid are ignored while in GRANT.
- Fairness: a continuously requesting input waits at most N-1 packets.
- Wrap-around: sel=N-1 completing gives ptr=0.
- Single-beat packet (in_last=1 on first beat): GRANT lasts 1 cycle if out_ready=1.
- Simultaneous in_valid on all inputs with ptr=k: grant k.
- Reset mid-packet: grant dropped immediately on the next edge, no further beats; consumer sees a truncated packet (upstream framing is not repaired).
- X-safety: out_data is driven from in_data[sel] in every state (no latch). Only out_valid qualifies it.

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic {S_IDLE, S_GRANT} arb_state_t
  - function rr_pick(valid[N], ptr) returning the index
- Sub-module: the existing mux8 (generalised mux_n of width W), instantiated with select=sel for out_data.
- Priority search and ptr/state FSM stay in rr_mux_arbiter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all in_valid=0 -> sel=0, busy=0, out_valid=0, in_ready=0 on every cycle.
2. Single requester: in_valid[3]=1, data 8'hA5, last=1, out_ready=1 -> cycle+1: sel=3, out_data=A5, in_ready=8'b0000_1000; cycle+2: busy=0, ptr=4.
3. Round-robin: all in_valid=1, every beat last=1, out_ready=1 -> grant order 0,1,2,…,7,0, one bubble between each.
4. Packet lock and backpressure: req 2 sends 3 beats (last on the 3rd) while req 5 also valid; out_ready toggles 1,0,1,0,1 -> sel stays 2 until the 3rd beat transfers; in_ready[5]=0 throughout; then grant goes to 5.
5. Requester gap: granted req 6 drops in_valid for 2 cycles mid-packet -> out_valid=0 for those cycles, sel=6 held, no grant change.
6. Reset mid-packet: rst=1 during beat 2 of req 1's 4-beat packet -> next cycle state=IDLE, in_ready=0, ptr=0; after release, a pending req 1 is granted first.
